// File: rtl/mem_access_ctrl.sv
// Memory-stage data-access controller: byte-lane decode, misalignment detection,
// and a req/ack data-bus transaction with timeout that stalls the pipeline.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_is_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic [3:0]  ld_mask,
    output logic        ld_signed,
    output logic        bus_err,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic [31:0] exc_badaddr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            2'd0:    be = 4'b0001 << lo;
            2'd1:    be = lo[1] ? 4'b1100 : 4'b0011;
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] rep;
        case (size)
            2'd0:    rep = {4{wd[7:0]}};
            2'd1:    rep = {2{wd[15:0]}};
            default: rep = wd;
        endcase
        return rep;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = lo[0];
            2'd2:    mis = (lo != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    state_e            state_q, state_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic              ld_valid_q, ld_valid_d;
    logic [31:0]       ld_data_q, ld_data_d;
    logic [3:0]        ld_mask_q, ld_mask_d;
    logic              ld_signed_q, ld_signed_d;
    logic              bus_err_q, bus_err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              live_s;
    logic              mis_s;
    logic              accept_s;
    logic              exc_s;
    logic [3:0]        be_s;

    assign live_s   = req_valid & ~flush;
    assign mis_s    = misaligned(req_size, req_addr[1:0]);
    assign be_s     = lane_be(req_size, req_addr[1:0]);
    assign accept_s = live_s & ~mis_s & (state_q == S_IDLE);
    assign exc_s    = live_s & mis_s & (state_q == S_IDLE);

    // Stall and address-exception outputs, combinational from the request.
    always_comb begin
        stall       = live_s & ~mis_s & ((state_q == S_IDLE) | (state_q == S_BUSY));
        exc_adel    = exc_s & ~req_is_store;
        exc_ades    = exc_s & req_is_store;
        if (exc_s) begin
            exc_badaddr = req_addr;
        end else begin
            exc_badaddr = 32'h0000_0000;
        end
    end

    // Next-state logic for the access FSM and its registered outputs.
    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        ld_valid_d  = 1'b0;
        ld_data_d   = ld_data_q;
        ld_mask_d   = ld_mask_q;
        ld_signed_d = ld_signed_q;
        bus_err_d   = 1'b0;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    bus_addr_d  = {req_addr[31:2], 2'b00};
                    bus_be_d    = be_s;
                    bus_wdata_d = lane_wdata(req_size, req_wdata);
                    bus_we_d    = req_is_store;
                    ld_mask_d   = req_is_store ? 4'b0000 : be_s;
                    ld_signed_d = req_signed;
                    bus_req_d   = 1'b1;
                    cnt_d       = {CNT_W{1'b0}};
                    state_d     = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (bus_ack) begin
                    if (!bus_we_q) begin
                        ld_data_d  = bus_rdata;
                        ld_valid_d = 1'b1;
                    end else begin
                        ld_valid_d = 1'b0;
                    end
                    bus_req_d = 1'b0;
                    state_d   = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    // Timed out: drop the request and report a bus error instead of data.
                    bus_req_d = 1'b0;
                    ld_data_d = 32'h0000_0000;
                    bus_err_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0000_0000;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0000_0000;
            ld_valid_q  <= 1'b0;
            ld_data_q   <= 32'h0000_0000;
            ld_mask_q   <= 4'b0000;
            ld_signed_q <= 1'b0;
            bus_err_q   <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            ld_valid_q  <= ld_valid_d;
            ld_data_q   <= ld_data_d;
            ld_mask_q   <= ld_mask_d;
            ld_signed_q <= ld_signed_d;
            bus_err_q   <= bus_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign ld_valid  = ld_valid_q;
    assign ld_data   = ld_data_q;
    assign ld_mask   = ld_mask_q;
    assign ld_signed = ld_signed_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl, built with TIMEOUT=8.
module tb_mem_access_ctrl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_is_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        flush;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [3:0]  ld_mask;
    logic        ld_signed;
    logic        bus_err;
    logic        exc_adel;
    logic        exc_ades;
    logic [31:0] exc_badaddr;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_ctrl #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_is_store(req_is_store), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .flush(flush), .stall(stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_mask(ld_mask), .ld_signed(ld_signed),
        .bus_err(bus_err), .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_badaddr(exc_badaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic st, input logic [1:0] sz, input logic sg,
                           input logic [31:0] ad, input logic [31:0] wd);
        req_valid    = 1'b1;
        req_is_store = st;
        req_size     = sz;
        req_signed   = sg;
        req_addr     = ad;
        req_wdata    = wd;
    endtask

    initial begin
        int  rq_cnt;
        int  er_cnt;
        int  lv_cnt;
        bit  seen;

        reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; flush = 1'b0;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        tick(); tick();
        @(negedge clk);
        check_val("rst_bus_req", {31'h0, bus_req}, 32'h0);
        check_val("rst_ld_valid", {31'h0, ld_valid}, 32'h0);
        check_val("rst_bus_addr", bus_addr, 32'h0);
        check_val("rst_ld_data", ld_data, 32'h0);
        check_val("rst_mask_be", {24'h0, ld_mask, bus_be}, 32'h0);
        tick();
        reset = 1'b0;

        // Load byte, signed, ack on second BUSY cycle
        set_req(1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0);
        @(negedge clk);
        check_val("lb_stall_idle", {31'h0, stall}, 32'h1);
        check_val("lb_req_idle", {31'h0, bus_req}, 32'h0);
        tick();
        @(negedge clk);
        check_val("lb_bus_req", {31'h0, bus_req}, 32'h1);
        check_val("lb_bus_addr", bus_addr, 32'h0000_1000);
        check_val("lb_bus_be", {28'h0, bus_be}, 32'h8);
        check_val("lb_bus_we", {31'h0, bus_we}, 32'h0);
        check_val("lb_stall_b1", {31'h0, stall}, 32'h1);
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h8011_2233;
        @(negedge clk);
        check_val("lb_stall_b2", {31'h0, stall}, 32'h1);
        check_val("lb_ldv_b2", {31'h0, ld_valid}, 32'h0);
        tick();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        @(negedge clk);
        check_val("lb_ld_valid", {31'h0, ld_valid}, 32'h1);
        check_val("lb_ld_data", ld_data, 32'h8011_2233);
        check_val("lb_ld_mask", {28'h0, ld_mask}, 32'h8);
        check_val("lb_ld_signed", {31'h0, ld_signed}, 32'h1);
        check_val("lb_stall_done", {31'h0, stall}, 32'h0);
        check_val("lb_req_done", {31'h0, bus_req}, 32'h0);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check_val("lb_ldv_after", {31'h0, ld_valid}, 32'h0);

        // Store half, immediate ack
        tick();
        set_req(1'b1, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_BEEF);
        @(negedge clk);
        check_val("sh_stall_idle", {31'h0, stall}, 32'h1);
        tick();
        bus_ack = 1'b1;
        @(negedge clk);
        check_val("sh_bus_we", {31'h0, bus_we}, 32'h1);
        check_val("sh_bus_be", {28'h0, bus_be}, 32'hC);
        check_val("sh_bus_wdata", bus_wdata, 32'hBEEF_BEEF);
        check_val("sh_bus_addr", bus_addr, 32'h0000_2000);
        check_val("sh_stall_b1", {31'h0, stall}, 32'h1);
        tick();
        bus_ack = 1'b0;
        @(negedge clk);
        check_val("sh_ld_valid", {31'h0, ld_valid}, 32'h0);
        check_val("sh_stall_done", {31'h0, stall}, 32'h0);
        check_val("sh_ld_mask", {28'h0, ld_mask}, 32'h0);
        check_val("sh_ld_data_kept", ld_data, 32'h8011_2233);
        tick();
        req_valid = 1'b0;

        // Misaligned load word, then reserved-size store
        tick();
        set_req(1'b0, 2'd2, 1'b0, 32'h0000_1001, 32'h0);
        @(negedge clk);
        check_val("mis_adel", {31'h0, exc_adel}, 32'h1);
        check_val("mis_ades0", {31'h0, exc_ades}, 32'h0);
        check_val("mis_badaddr", exc_badaddr, 32'h0000_1001);
        check_val("mis_stall", {31'h0, stall}, 32'h0);
        tick();
        @(negedge clk);
        check_val("mis_no_req", {31'h0, bus_req}, 32'h0);
        set_req(1'b1, 2'd3, 1'b0, 32'h0000_3000, 32'h1234_5678);
        #1;
        check_val("rsv_ades", {31'h0, exc_ades}, 32'h1);
        check_val("rsv_adel0", {31'h0, exc_adel}, 32'h0);
        check_val("rsv_badaddr", exc_badaddr, 32'h0000_3000);
        check_val("rsv_stall", {31'h0, stall}, 32'h0);
        tick();
        @(negedge clk);
        check_val("rsv_no_req", {31'h0, bus_req}, 32'h0);
        req_valid = 1'b0;
        #1;
        check_val("exc_clear", {exc_badaddr[29:0], exc_adel, exc_ades}, 32'h0);

        // Timeout: load word, never acked
        tick();
        set_req(1'b0, 2'd2, 1'b0, 32'h0000_4000, 32'h0);
        rq_cnt = 0; er_cnt = 0; lv_cnt = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus_req) rq_cnt++;
            if (ld_valid) lv_cnt++;
            if (bus_err) begin
                er_cnt++;
                seen = 1'b1;
            end
        end
        check_val("to_seen", {31'h0, seen}, 32'h1);
        check_val("to_req_cycles", rq_cnt, 32'd8);
        check_val("to_err_pulses", er_cnt, 32'd1);
        check_val("to_ld_valid", lv_cnt, 32'd0);
        check_val("to_ld_data", ld_data, 32'h0);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check_val("to_err_cleared", {31'h0, bus_err}, 32'h0);
        check_val("to_req_idle", {31'h0, bus_req}, 32'h0);

        // Reset in third BUSY cycle, late ack afterwards
        tick();
        set_req(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0);
        tick(); tick(); tick();
        reset = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        check_val("rm_req_b3", {31'h0, bus_req}, 32'h1);
        tick();
        reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_val("rm_req_after", {31'h0, bus_req}, 32'h0);
        check_val("rm_stall_after", {31'h0, stall}, 32'h0);
        check_val("rm_addr_after", bus_addr, 32'h0);
        check_val("rm_ld_data", ld_data, 32'h0);
        tick();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        @(negedge clk);
        check_val("rm_no_ldv", {31'h0, ld_valid}, 32'h0);
        check_val("rm_req_idle", {31'h0, bus_req}, 32'h0);

        // Flush in IDLE blocks the request; flush during BUSY is ignored
        tick();
        set_req(1'b0, 2'd2, 1'b0, 32'h0000_6000, 32'h0);
        flush = 1'b1;
        @(negedge clk);
        check_val("fl_stall", {31'h0, stall}, 32'h0);
        tick();
        @(negedge clk);
        check_val("fl_no_req", {31'h0, bus_req}, 32'h0);
        flush = 1'b0;
        #1;
        check_val("fl_stall_on", {31'h0, stall}, 32'h1);
        tick();
        flush = 1'b1;
        @(negedge clk);
        check_val("fb_req", {31'h0, bus_req}, 32'h1);
        tick();
        flush = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        @(negedge clk);
        check_val("fb_req_b2", {31'h0, bus_req}, 32'h1);
        tick();
        bus_ack = 1'b0; bus_rdata = 32'h0;
        @(negedge clk);
        check_val("fb_ld_valid", {31'h0, ld_valid}, 32'h1);
        check_val("fb_ld_data", ld_data, 32'h1234_5678);
        check_val("fb_ld_mask", {28'h0, ld_mask}, 32'hF);
        check_val("fb_ld_signed", {31'h0, ld_signed}, 32'h0);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check_val("fb_ldv_after", {31'h0, ld_valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage data-access controller between the EX/MEM pipeline register and data memory; feeds the load-extension unit.
- Decodes access size/address into byte lanes, replicates store data, flags misaligned accesses, runs a variable-latency req/ack bus transaction with timeout, stalls the pipeline meanwhile.
- Presents the captured raw word plus byte-lane mask and signedness downstream for extension.

Parameters:
- TIMEOUT, 255: max BUSY cycles without bus_ack before bus error; legal range 1..65535.
- CNT_W, 16: timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  1  MEM stage holds a load/store
- req_is_store  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved
- req_signed  in  1  load sign-extension request
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- flush  in  1  kill request in IDLE (later-stage exception)
- stall  out  1  freeze PC/IF/ID/EX/MEM
- bus_req  out  1  transaction request, registered
- bus_we  out  1  write enable, registered
- bus_addr  out  32  word address, {req_addr[31:2],2'b00}
- bus_be  out  4  byte enables, bit i = bits [8i+7:8i]
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  completion, one cycle
- bus_rdata  in  32  read word, valid with bus_ack
- ld_valid  out  1  one-cycle pulse: load result valid
- ld_data  out  32  captured raw word
- ld_mask  out  4  byte-lane mask for extension (0 for stores)
- ld_signed  out  1  registered req_signed
- bus_err  out  1  one-cycle pulse: timeout
- exc_adel  out  1  misaligned load, combinational
- exc_ades  out  1  misaligned store, combinational
- exc_badaddr  out  32  req_addr while exc_* high, else 0

Behaviour:
- Reset values: state IDLE; bus_req, bus_we, ld_valid, bus_err, ld_signed = 0; bus_addr, bus_be, bus_wdata, ld_data, ld_mask = 0; counter 0.
- Lane decode: byte -> be = 1<<addr[1:0]; half -> addr[1] ? 4'b1100 : 4'b0011; word -> 4'b1111.
- Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0; size 3 always. In IDLE with req_valid & ~flush & misaligned: exc_adel (load) or exc_ades (store) high same cycle, exc_badaddr = req_addr; no bus activity; stall=0; state stays IDLE.
- FSM:
  - IDLE: accept when req_valid & ~flush & aligned; register bus_addr/be/wdata/we, ld_mask (be if load, else 0), ld_signed; bus_req<=1; counter<=0 -> BUSY.
  - BUSY: bus_req held, bus outputs stable. bus_ack -> ld_data<=bus_rdata (loads; stores leave it unchanged), bus_req<=0 -> DONE. Else counter++; when counter == TIMEOUT-1 without ack -> bus_req<=0, ld_data<=0, bus_err pulse -> DONE.
  - DONE: ld_valid=1 for loads (0 after timeout), bus_err=1 if timed out; stall=0; unconditionally -> IDLE next cycle.
- stall = req_valid & ~flush & aligned & (state==IDLE | state==BUSY). stall=0 in DONE so the pipeline advances on that edge.
- Latency: ack in nth BUSY cycle -> ld_valid exactly one cycle later; total stall = n+1 cycles.
- flush ignored in BUSY/DONE; an accepted transaction always completes.
- bus_ack outside BUSY is ignored.
- Reset mid-transaction: next edge returns to IDLE with all outputs at reset values; a late ack is ignored.

Test Plan:
- Load byte, req_addr=0x00001003, size=0, signed=1, ack on 2nd BUSY cycle, rdata=0x80112233 -> bus_addr=0x1000, bus_be=4'b1000, stall 3 cycles, then ld_valid=1, ld_data=0x80112233, ld_mask=4'b1000, ld_signed=1.
- Store half, req_addr=0x00002002, wdata=0x0000BEEF, immediate ack -> bus_we=1, bus_be=4'b1100, bus_wdata=0xBEEFBEEF, ld_valid stays 0, stall 2 cycles.
- Load word, req_addr=0x00001001 -> exc_adel=1 and exc_badaddr=0x00001001 same cycle; bus_req never rises; stall=0. Repeat with size=3 store -> exc_ades=1.
- TIMEOUT=8, load word, no ack -> bus_req high exactly 8 cycles, then bus_err one-cycle pulse, ld_valid=0, FSM back to IDLE.
- Assert reset in 3rd BUSY cycle, pulse bus_ack in the following cycle -> bus_req=0 and stall=0 after the reset edge; no ld_valid pulse.
- flush=1 with a valid aligned load in IDLE -> no bus_req, stall=0. flush asserted during BUSY -> transaction completes and ld_valid pulses normally.
